// File: rtl/burst_collector_pkg.sv
// Shared types for burst_collector: FSM state encoding, beat count and lane index.
package burst_collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } bc_state_e;

  localparam int BEATS = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(BEATS - 1);

endpackage

// File: rtl/rdy_timeout_ctr.sv
// Per-beat stall timer: counts cycles without rdy, flags when the last allowed cycle is reached.
module rdy_timeout_ctr
  import burst_collector_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Saturates so a long stall can never wrap back into a small count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/burst_collector.sv
// Four-beat request sequencer and word assembler with valid/ready output.
// Define BURST_COLLECTOR_TIMEOUT_EN to add the per-beat rdy timeout abort.
module burst_collector
  import burst_collector_pkg::*;
#(
  parameter int ADDR    = 22,
  parameter int DATA    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [1:0]            addr,
  input  logic [DATA-1:0]       data,
  input  logic                  rdy,
  input  logic [ADDR-1:3]       newaddr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BEATS*DATA-1:0] out_data,
  output logic [ADDR-1:3]       out_addr,
  output logic                  busy,
  output logic                  err
);

  bc_state_e state;
  lane_t     lane;
  logic      expired;

`ifdef BURST_COLLECTOR_TIMEOUT_EN
  rdy_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != REQ) || rdy),
    .en     ((state == REQ) && !rdy),
    .expired(expired)
  );
`else
  // Without the timer REQ waits forever; TIMEOUT is legal (>= 1) so this is constant 0.
  assign expired = (TIMEOUT < 0);
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      addr      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= REQ;
            lane  <= '0;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (rdy) begin
            out_data[lane*DATA +: DATA] <= data;
            if (lane == '0) out_addr <= newaddr;
            if (lane == LAST_LANE) begin
              state     <= DONE;
              out_valid <= 1'b1;
              addr      <= '0;
            end else begin
              lane <= lane + 1'b1;
              addr <= lane + 1'b1;
            end
          end else if (expired) begin
            // Abort keeps the partial word; it is simply never presented.
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            addr  <= '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_collector.sv
// Directed, scoreboard-based bench for burst_collector (works with or without BURST_COLLECTOR_TIMEOUT_EN).
module tb_burst_collector;

  localparam int ADDR    = 22;
  localparam int DATA    = 5;
  localparam int TIMEOUT = 15;
  localparam int W       = 4 * DATA;
  localparam int AW      = ADDR - 3;

  logic            clk = 1'b0;
  logic            rst, start, rdy, out_ready;
  logic [1:0]      addr;
  logic [DATA-1:0] data;
  logic [ADDR-1:3] newaddr, out_addr;
  logic            out_valid, busy, err;
  logic [W-1:0]    out_data;

  typedef struct {
    logic [W-1:0]  word;
    logic [AW-1:0] oa;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_word;

  burst_collector #(
    .ADDR(ADDR), .DATA(DATA), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .data     (data),
    .rdy      (rdy),
    .newaddr  (newaddr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_oaddr"}, out_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Issues one burst with `gap` rdy-low cycles before every beat; ends in the first DONE cycle.
  task automatic run_burst(input logic [W-1:0] word, input logic [AW-1:0] na, input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("req_busy", busy, 1);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        rdy     = 1'b0;
        data    = DATA'($urandom);
        newaddr = AW'($urandom);
        chk("gap_addr", addr, b);
        chk("gap_err", err, 0);
        tick();
      end
      rdy     = 1'b1;
      data    = word[b*DATA +: DATA];
      newaddr = (b == 0) ? na : ~na;
      chk("beat_addr", addr, b);
      chk("beat_valid", out_valid, 0);
      tick();
    end
    rdy = 1'b0;
    sb.push_back('{word, na});
    last_word = word;
    chk("valid_rise", out_valid, 1);
    chk("done_busy", busy, 1);
    chk("done_err", err, 0);
  endtask

  task automatic consume();
    exp_t e;
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_data", out_data, e.word);
      chk("out_addr", out_addr, e.oa);
    end
    chk("valid_hold", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_fall", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_addr", addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]  w;
    logic [AW-1:0] na;

    rst = 1'b1; start = 1'b0; rdy = 1'b0; out_ready = 1'b0;
    data = '0; newaddr = '0; last_word = '0;
    repeat (3) tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_busy", busy, 0);

    // Back-to-back beats, fixed pattern.
    run_burst({5'h04, 5'h13, 5'h02, 5'h11}, 19'h1ABCD, 0);
    consume();

    // Stalled slave: 3-cycle gaps, restarted in the cycle right after DONE->IDLE.
    w  = W'($urandom);
    na = AW'($urandom);
    run_burst(w, na, 3);
    consume();

    // Consumer backpressure with start/rdy toggling.
    run_burst(20'hABCDE, 19'h2_5A5A, 0);
    for (int i = 0; i < 10; i++) begin
      start   = i[0];
      rdy     = ~i[0];
      data    = DATA'($urandom);
      newaddr = AW'($urandom);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_data", out_data, sb[0].word);
      chk("bp_oaddr", out_addr, sb[0].oa);
    end
    start = 1'b0;
    rdy   = 1'b0;
    consume();
    tick();
    chk("bp_no_restart", busy, 0);

    // Timeout: beat 0, then rdy held low.
    start = 1'b1;
    tick();
    start   = 1'b0;
    rdy     = 1'b1;
    data    = 5'h1F;
    newaddr = 19'h12345;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_wait_err", err, 0);
      chk("to_wait_busy", busy, 1);
      chk("to_wait_addr", addr, 1);
      tick();
    end
`ifdef BURST_COLLECTOR_TIMEOUT_EN
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_valid", out_valid, 0);
    chk("to_addr", addr, 0);
    chk("to_partial", out_data, {last_word[W-1:DATA], 5'h1F});
    chk("to_oaddr", out_addr, 19'h12345);
    tick();
    chk("to_err_once", err, 0);
    chk("to_idle_busy", busy, 0);
    chk("to_idle_valid", out_valid, 0);
`else
    chk("nto_err", err, 0);
    chk("nto_busy", busy, 1);
    chk("nto_addr", addr, 1);
    chk("nto_valid", out_valid, 0);
    for (int b = 1; b < 4; b++) begin
      rdy  = 1'b1;
      data = DATA'(b + 8);
      tick();
    end
    rdy = 1'b0;
    sb.push_back('{{5'h0B, 5'h0A, 5'h09, 5'h1F}, 19'h12345});
    chk("nto_valid_rise", out_valid, 1);
    consume();
`endif

    // Reset mid-burst after beat 2, then a fresh full burst.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rdy     = 1'b1;
      data    = DATA'(b + 3);
      newaddr = 19'h7_0F0F;
      tick();
    end
    rdy = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle_zero("mid_rst");
    rst = 1'b0;
    run_burst(20'h5_3C71, 19'h0_0F1E, 1);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_collector.md
# burst_collector

Request sequencer and beat assembler that sits directly upstream and downstream of the addr/data/rdy slave (parameters ADDR, DATA).

- It drives the slave's 2-bit `addr` through lanes 0..3 and captures one `data` beat per `rdy`.
- It latches the slave's `newaddr` on the first beat.
- It presents the assembled 4-beat word with a valid/ready handshake to the next consumer.
- A per-beat timeout aborts a burst if the slave stalls.

## Interface

- ADDR, 22, slave address width; `newaddr`/`out_addr` span [ADDR-1:3]; legal ADDR ≥ 4
- DATA, 5, slave data beat width; legal DATA ≥ 1
- TIMEOUT, 15, max consecutive cycles without `rdy` per beat; legal TIMEOUT ≥ 1
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one burst; sampled only in IDLE
- addr  out  2  lane index to slave
- data  in  DATA  slave beat
- rdy  in  1  slave beat-valid strobe
- newaddr  in  ADDR-3 [ADDR-1:3]  slave address output
- out_valid  out  1  assembled word available
- out_ready  in  1  consumer accepts word
- out_data  out  4*DATA  lane k at [k*DATA +: DATA]
- out_addr  out  ADDR-3 [ADDR-1:3]  `newaddr` captured on beat 0
- busy  out  1  high in REQ and DONE
- err  out  1  one-cycle timeout pulse

## Operation

- Reset: all outputs 0, state IDLE, lane counter 0, timer 0, `out_data`/`out_addr` cleared.
- FSM states are IDLE, REQ and DONE.
- **IDLE**
  - `addr` = 0.
  - `start` = 1 → REQ; lane = 0 and timer = 0 on entry.
- **REQ**
  - `addr` = lane.
  - `rdy` = 1:
    - writes `data` into lane slot of `out_data`;
    - if lane = 0, also loads `out_addr` ← `newaddr`;
    - resets the timer.
  - Lane = 3 with `rdy` → DONE. Otherwise lane increments.
  - `rdy` = 0: timer increments.
  - Timer = TIMEOUT-1 with `rdy` = 0 → IDLE, `err` = 1 for the next cycle only.
    - `out_data` keeps its partial contents.
    - `out_valid` is never raised.
- **DONE**
  - `out_valid` = 1; `out_data`/`out_addr` are held stable.
  - `out_ready` = 1 → IDLE.
  - `rdy` is ignored.
- `start` is ignored in REQ and DONE. It is not queued.
- `start` may be asserted in the cycle after a DONE→IDLE transition.
- Lane counter is 2 bits and never wraps within a burst. The burst exits on lane 3.
- Timer width is $clog2(TIMEOUT+1). It saturates, and it is never compared across beats.

## Timing

- `start` sampled in cycle 0 → REQ in cycle 1 with `addr` = 0.
- With `rdy` held high, beats are captured at the ends of cycles 1–4; `addr` shows 0, 1, 2, 3.
- `out_valid` rises in cycle 5. Minimum start-to-valid latency is 5 cycles.
- `out_ready` is sampled while `out_valid` = 1. `out_valid` deasserts the following cycle.
- Max issue rate is one burst per 6 cycles.
- Timeout: after the last `rdy` (or REQ entry), `err` asserts TIMEOUT+1 cycles later and `busy` drops in the same cycle.
- Reset mid-burst (any state): next cycle is IDLE, all outputs 0, no `err` pulse.
- All outputs are registered.

## Configuration

- `BURST_COLLECTOR_TIMEOUT_EN` defined: timer and timeout abort present as described.
- Undefined:
  - No timer is instantiated.
  - REQ waits indefinitely for `rdy`.
  - `err` is tied to 0.
  - TIMEOUT is unused.

## Structure

- `burst_collector_pkg`:
  - state enum `bc_state_e` {IDLE, REQ, DONE};
  - localparam BEATS = 4;
  - `lane_t` typedef, 2 bits.
- One sub-module, `rdy_timeout_ctr`:
  - parameter TIMEOUT;
  - inputs `clk`, `rst`, `clr`, `en`;
  - output `expired`.
  - It is instantiated only under `BURST_COLLECTOR_TIMEOUT_EN`.

## Test plan

- Back-to-back beats:
  - Stimulus: `start`; `rdy` = 1 every REQ cycle; data 0x11, 0x02, 0x13, 0x04 (DATA = 5); `newaddr` = 0x1ABCD on beat 0.
  - Response: `out_valid` in cycle 5; `out_data` = {0x04, 0x13, 0x02, 0x11}; `out_addr` = 0x1ABCD.
- Stalled slave:
  - Stimulus: `rdy` gaps of 3 cycles before each beat, TIMEOUT = 15.
  - Response: no `err`; `addr` holds each lane through the gap; `out_valid` in cycle 17.
- Timeout:
  - Stimulus: beat 0 then `rdy` held 0.
  - Response: `err` pulses exactly once TIMEOUT+1 cycles later; `busy` → 0; `out_valid` stays 0. Repeat with the macro undefined: `busy` stays 1 and `err` stays 0.
- Consumer backpressure:
  - Stimulus: `out_ready` = 0 for 10 cycles in DONE, with `start` and `rdy` toggling.
  - Response: `out_data`/`out_addr` stable; no new burst starts; the cycle after `out_ready` = 1, `out_valid` = 0.
- Reset mid-burst:
  - Stimulus: `rst` after beat 2.
  - Response: next cycle all outputs 0. A following `start` restarts at `addr` = 0 and produces a full fresh word.
